// File: rtl/seq_stream_ctrl.sv
// Run sequencer for the serial sequence detector.
// Clears the detector, shifts a pattern LSB first, drains it and counts hits.
module seq_stream_ctrl #(
    parameter int PAT_W     = 16,
    parameter int CNT_W     = 6,
    parameter int FLUSH_CYC = 3,
    localparam int LEN_W    = $clog2(PAT_W + 1),
    localparam int OFS_W    = LEN_W + 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    output logic             det_reset,
    output logic             det_in,
    input  logic             det_success,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] hits,
    output logic             overflow,
    output logic [OFS_W-1:0] first_hit_cyc
);

    localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_SHIFT,
        S_FLUSH,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [PAT_W-1:0]   pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [OFS_W-1:0]   ofs_q, ofs_d;
    logic [CNT_W-1:0]   hits_q, hits_d;
    logic               ovf_q, ovf_d;
    logic [OFS_W-1:0]   first_q, first_d;
    logic               det_reset_q, det_reset_d;
    logic               det_in_q, det_in_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               armed_q;
    logic [LEN_W-1:0]   len_clamp;
    logic [OFS_W-1:0]   shift_end;
    logic [OFS_W-1:0]   flush_end;

    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        len_d     = len_q;
        ofs_d     = ofs_q;
        hits_d    = hits_q;
        ovf_d     = ovf_q;
        first_d   = first_q;
        len_clamp = (len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : len;
        shift_end = OFS_W'(len_q) - OFS_W'(1);
        flush_end = OFS_W'(len_q) + OFS_W'(FLUSH_CYC) - OFS_W'(1);

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    pat_d   = pattern;
                    len_d   = len_clamp;
                    ofs_d   = '0;
                    hits_d  = '0;
                    ovf_d   = 1'b0;
                    first_d = '1;
                    state_d = (len_clamp != '0) ? S_CLEAR : S_DONE;
                end
            end
            S_CLEAR: begin
                ofs_d   = '0;
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                ofs_d = ofs_q + OFS_W'(1);
                if (ofs_q == shift_end) begin
                    state_d = (FLUSH_CYC == 0) ? S_DONE : S_FLUSH;
                end
            end
            S_FLUSH: begin
                ofs_d = ofs_q + OFS_W'(1);
                if (ofs_q == flush_end) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Offset keeps running through FLUSH, so it doubles as hit timestamp
        if ((state_q == S_SHIFT || state_q == S_FLUSH) && det_success) begin
            if (first_q == '1) begin
                first_d = ofs_q;
            end
            if (hits_q == '1) begin
                ovf_d = 1'b1;
            end else begin
                hits_d = hits_q + CNT_W'(1);
            end
        end

        // Outputs are registered, so they are derived from the next state
        det_in_d    = (state_d == S_SHIFT) && pat_d[ofs_d[IDX_W-1:0]];
        det_reset_d = armed_q && (state_d != S_CLEAR);
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            pat_q       <= '0;
            len_q       <= '0;
            ofs_q       <= '0;
            hits_q      <= '0;
            ovf_q       <= 1'b0;
            first_q     <= '1;
            det_reset_q <= 1'b0;
            det_in_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            armed_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pat_q       <= pat_d;
            len_q       <= len_d;
            ofs_q       <= ofs_d;
            hits_q      <= hits_d;
            ovf_q       <= ovf_d;
            first_q     <= first_d;
            det_reset_q <= det_reset_d;
            det_in_q    <= det_in_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            armed_q     <= 1'b1;
        end
    end

    assign det_reset     = det_reset_q;
    assign det_in        = det_in_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign hits          = hits_q;
    assign overflow      = ovf_q;
    assign first_hit_cyc = first_q;

endmodule
